// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the ID-stage branch resolve unit.
//   - forward-select codes driven by the branch forwarding stage
//   - stall FSM state encoding
//   - default datapath width
package branch_resolve_unit_pkg;

  localparam int BRU_DATA_W = 32;

  // forwardAD / forwardBD operand source codes
  localparam logic [1:0] FWD_RF        = 2'b00;
  localparam logic [1:0] FWD_EXMEM_ALU = 2'b01;
  localparam logic [1:0] FWD_EXMEM_MEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB     = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } bru_state_e;

  // Counter value loaded on entry to STALL. An ALU producer only needs the
  // detection cycle; a load needs lbs stall cycles in total, one of which
  // is the detection cycle.
  function automatic logic [1:0] stall_cnt_init(input logic is_load, input int lbs);
    logic [1:0] init;
    if (is_load) begin
      init = 2'(lbs - 1);
    end else begin
      init = 2'b00;
    end
    return init;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_operand_mux.sv
// branch_operand_mux: 4:1 forwarding select for one branch comparison operand.
// Ports:
//   sel               in   2       forward-select code (FWD_*)
//   rf_data           in   DATA_W  register-file read data
//   alu_result_exmem  in   DATA_W  EX/MEM ALU result
//   mem_rdata_exmem   in   DATA_W  data-memory read data in MEM
//   wb_data_memwb     in   DATA_W  MEM/WB writeback data
//   operand           out  DATA_W  selected operand
module branch_operand_mux
  import branch_resolve_unit_pkg::*;
#(
  parameter int DATA_W = BRU_DATA_W
) (
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] rf_data,
  input  logic [DATA_W-1:0] alu_result_exmem,
  input  logic [DATA_W-1:0] mem_rdata_exmem,
  input  logic [DATA_W-1:0] wb_data_memwb,
  output logic [DATA_W-1:0] operand
);

  // forward select
  always_comb begin
    operand = rf_data;
    case (sel)
      FWD_RF:        operand = rf_data;
      FWD_EXMEM_ALU: operand = alu_result_exmem;
      FWD_EXMEM_MEM: operand = mem_rdata_exmem;
      FWD_MEMWB:     operand = wb_data_memwb;
      default:       operand = rf_data;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: ID-stage beq/bne resolution with forwarded operands,
// branch-hazard stall FSM and saturating perf counters.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   branch, branch_ne               ID holds beq/bne; 1 = bne
//   rs, rt, rs_data, rt_data        ID sources and register-file data
//   forwardAD, forwardBD            operand forward-select codes
//   alu_result_exmem, mem_rdata_exmem, wb_data_memwb   forwarding sources
//   reg_write_idex, mem_read_idex, writebackreg_idex   producer in ID/EX
//   pc_plus4_ifid, imm_ext          branch target inputs
//   stall_if, stall_id, bubble_idex stall controls (always equal)
//   pc_src, flush_ifid              taken-branch redirect and IF/ID kill
//   branch_target                   pc_plus4_ifid + (imm_ext << 2)
//   taken_count, stall_count        saturating perf counters
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DATA_W             = BRU_DATA_W,
  parameter int LOAD_BRANCH_STALLS = 1,
  parameter int PERF_W             = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch,
  input  logic              branch_ne,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [1:0]        forwardAD,
  input  logic [1:0]        forwardBD,
  input  logic [DATA_W-1:0] alu_result_exmem,
  input  logic [DATA_W-1:0] mem_rdata_exmem,
  input  logic [DATA_W-1:0] wb_data_memwb,
  input  logic              reg_write_idex,
  input  logic              mem_read_idex,
  input  logic [4:0]        writebackreg_idex,
  input  logic [DATA_W-1:0] pc_plus4_ifid,
  input  logic [DATA_W-1:0] imm_ext,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_idex,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic              flush_ifid,
  output logic [PERF_W-1:0] taken_count,
  output logic [PERF_W-1:0] stall_count
);

  localparam logic [1:0]        LOAD_CNT_INIT = stall_cnt_init(1'b1, LOAD_BRANCH_STALLS);
  localparam logic [PERF_W-1:0] PERF_ONE      = {{(PERF_W-1){1'b0}}, 1'b1};

  bru_state_e  state;
  logic [1:0]  cnt;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic        hazard;
  logic        taken;
  logic        stall;
  logic        redirect;

  branch_operand_mux #(.DATA_W(DATA_W)) u_mux_a (
    .sel              (forwardAD),
    .rf_data          (rs_data),
    .alu_result_exmem (alu_result_exmem),
    .mem_rdata_exmem  (mem_rdata_exmem),
    .wb_data_memwb    (wb_data_memwb),
    .operand          (op_a)
  );

  branch_operand_mux #(.DATA_W(DATA_W)) u_mux_b (
    .sel              (forwardBD),
    .rf_data          (rt_data),
    .alu_result_exmem (alu_result_exmem),
    .mem_rdata_exmem  (mem_rdata_exmem),
    .wb_data_memwb    (wb_data_memwb),
    .operand          (op_b)
  );

  // A single hazard term covers rs, rt or both, so a double match is one stall sequence.
  assign hazard = branch & reg_write_idex & (writebackreg_idex != 5'd0) &
                  ((writebackreg_idex == rs) | (writebackreg_idex == rt));
  assign taken  = branch & ((op_a == op_b) ^ branch_ne);

  // stall decode: immediate in IDLE on detection, counter-driven in STALL, forced low in reset
  always_comb begin
    stall = 1'b0;
    if (reset) begin
      stall = 1'b0;
    end else if (state == ST_IDLE) begin
      stall = hazard;
    end else begin
      stall = (cnt != 2'd0);
    end
  end

  assign redirect      = taken & ~stall & ~reset;
  assign stall_if      = stall;
  assign stall_id      = stall;
  assign bubble_idex   = stall;
  assign pc_src        = redirect;
  assign flush_ifid    = redirect;
  assign branch_target = pc_plus4_ifid + {imm_ext[DATA_W-3:0], 2'b00};

  // branch-hazard stall FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hazard) begin
            state <= ST_STALL;
            cnt   <= mem_read_idex ? LOAD_CNT_INIT : 2'd0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_STALL: begin
          if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

  // saturating perf counters
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_count <= '0;
      stall_count <= '0;
    end else begin
      if (redirect && (taken_count != {PERF_W{1'b1}})) begin
        taken_count <= taken_count + PERF_ONE;
      end
      if (stall && (stall_count != {PERF_W{1'b1}})) begin
        stall_count <= stall_count + PERF_ONE;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch, branch_ne;
  logic [4:0]  rs, rt, writebackreg_idex;
  logic [31:0] rs_data, rt_data, alu_result_exmem, mem_rdata_exmem, wb_data_memwb;
  logic [1:0]  forwardAD, forwardBD;
  logic        reg_write_idex, mem_read_idex;
  logic [31:0] pc_plus4_ifid, imm_ext;

  logic        sif1, sid1, bub1, pcs1, fl1;
  logic [31:0] tgt1, tc1, sc1;
  logic        sif2, sid2, bub2, pcs2, fl2;
  logic [31:0] tgt2;
  logic [2:0]  tc2, sc2;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DATA_W(32), .LOAD_BRANCH_STALLS(1), .PERF_W(32)) u_lbs1 (
    .clk(clk), .reset(reset), .branch(branch), .branch_ne(branch_ne), .rs(rs), .rt(rt),
    .rs_data(rs_data), .rt_data(rt_data), .forwardAD(forwardAD), .forwardBD(forwardBD),
    .alu_result_exmem(alu_result_exmem), .mem_rdata_exmem(mem_rdata_exmem),
    .wb_data_memwb(wb_data_memwb), .reg_write_idex(reg_write_idex),
    .mem_read_idex(mem_read_idex), .writebackreg_idex(writebackreg_idex),
    .pc_plus4_ifid(pc_plus4_ifid), .imm_ext(imm_ext),
    .stall_if(sif1), .stall_id(sid1), .bubble_idex(bub1), .pc_src(pcs1),
    .branch_target(tgt1), .flush_ifid(fl1), .taken_count(tc1), .stall_count(sc1));

  branch_resolve_unit #(.DATA_W(32), .LOAD_BRANCH_STALLS(2), .PERF_W(3)) u_lbs2 (
    .clk(clk), .reset(reset), .branch(branch), .branch_ne(branch_ne), .rs(rs), .rt(rt),
    .rs_data(rs_data), .rt_data(rt_data), .forwardAD(forwardAD), .forwardBD(forwardBD),
    .alu_result_exmem(alu_result_exmem), .mem_rdata_exmem(mem_rdata_exmem),
    .wb_data_memwb(wb_data_memwb), .reg_write_idex(reg_write_idex),
    .mem_read_idex(mem_read_idex), .writebackreg_idex(writebackreg_idex),
    .pc_plus4_ifid(pc_plus4_ifid), .imm_ext(imm_ext),
    .stall_if(sif2), .stall_id(sid2), .bubble_idex(bub2), .pc_src(pcs2),
    .branch_target(tgt2), .flush_ifid(fl2), .taken_count(tc2), .stall_count(sc2));

  typedef struct packed {
    logic        stall;
    logic        pc_src;
    logic        chk_tgt;
    logic [31:0] tgt;
    logic        chk_cnt;
    logic [31:0] tc;
    logic [31:0] sc;
  } exp_t;

  exp_t        q[2][$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_tc[2];
  logic [31:0] m_sc[2];
  logic [31:0] cnt_max[2];

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut_lbs%0d: got %0h expected %0h at %0t", name, d + 1, act, exp, $time);
    end
  endtask

  // monitor: pop one expectation per DUT each cycle and compare away from the clock edge
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (q[d].size() > 0) begin
        exp_t e;
        logic s_if, s_id, s_bub, s_pc, s_fl;
        logic [31:0] s_tgt, s_tc, s_sc;
        e     = q[d].pop_front();
        s_if  = (d == 0) ? sif1 : sif2;
        s_id  = (d == 0) ? sid1 : sid2;
        s_bub = (d == 0) ? bub1 : bub2;
        s_pc  = (d == 0) ? pcs1 : pcs2;
        s_fl  = (d == 0) ? fl1  : fl2;
        s_tgt = (d == 0) ? tgt1 : tgt2;
        s_tc  = (d == 0) ? tc1  : {29'd0, tc2};
        s_sc  = (d == 0) ? sc1  : {29'd0, sc2};
        check("stall_if",    d, {31'd0, s_if},  {31'd0, e.stall});
        check("stall_id",    d, {31'd0, s_id},  {31'd0, e.stall});
        check("bubble_idex", d, {31'd0, s_bub}, {31'd0, e.stall});
        check("pc_src",      d, {31'd0, s_pc},  {31'd0, e.pc_src});
        check("flush_ifid",  d, {31'd0, s_fl},  {31'd0, e.pc_src});
        if (e.chk_tgt) check("branch_target", d, s_tgt, e.tgt);
        if (e.chk_cnt) begin
          check("taken_count", d, s_tc, e.tc);
          check("stall_count", d, s_sc, e.sc);
        end
      end
    end
  end

  task automatic set_in(input logic br, input logic ne, input logic [4:0] a, input logic [4:0] b,
                        input logic [31:0] ad, input logic [31:0] bd, input logic [1:0] fa,
                        input logic [1:0] fb, input logic rw, input logic mr, input logic [4:0] wr);
    branch = br; branch_ne = ne; rs = a; rt = b; rs_data = ad; rt_data = bd;
    forwardAD = fa; forwardBD = fb; reg_write_idex = rw; mem_read_idex = mr;
    writebackreg_idex = wr;
  endtask

  // push expected response for the inputs now applied, then advance one cycle
  task automatic step(input logic s1, input logic p1, input logic s2, input logic p2,
                      input logic [31:0] tgt);
    logic st[2];
    logic pc[2];
    st[0] = s1; st[1] = s2; pc[0] = p1; pc[1] = p2;
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      e.stall   = st[d];
      e.pc_src  = pc[d];
      e.chk_tgt = pc[d];
      e.tgt     = tgt;
      e.chk_cnt = !reset;
      e.tc      = m_tc[d];
      e.sc      = m_sc[d];
      q[d].push_back(e);
      if (reset) begin
        m_tc[d] = 32'd0;
        m_sc[d] = 32'd0;
      end else begin
        if (pc[d] && m_tc[d] != cnt_max[d]) m_tc[d] = m_tc[d] + 32'd1;
        if (st[d] && m_sc[d] != cnt_max[d]) m_sc[d] = m_sc[d] + 32'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    set_in(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    cnt_max[0] = 32'hFFFF_FFFF;
    cnt_max[1] = 32'd7;
    m_tc[0] = 32'd0; m_tc[1] = 32'd0; m_sc[0] = 32'd0; m_sc[1] = 32'd0;
    reset = 1'b1;
    alu_result_exmem = 32'd0; mem_rdata_exmem = 32'd0; wb_data_memwb = 32'd0;
    pc_plus4_ifid = 32'd0; imm_ext = 32'd0;
    set_in(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    reset = 1'b0;
    idle_cycle();  // reset state: no stall, counters zero

    // add $3 in ID/EX, beq $3,$4: one stall, then EX/MEM ALU forward resolves equal
    pc_plus4_ifid = 32'h100; imm_ext = 32'd4; alu_result_exmem = 32'd99;
    set_in(1'b1, 1'b0, 5'd3, 5'd4, 32'd10, 32'd99, 2'b00, 2'b00, 1'b1, 1'b0, 5'd3);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    set_in(1'b1, 1'b0, 5'd3, 5'd4, 32'd10, 32'd99, 2'b01, 2'b00, 1'b0, 1'b0, 5'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h110);
    idle_cycle();

    // lw $5 in ID/EX, bne $5,$0: LBS=1 resolves via code 10, LBS=2 via code 11
    pc_plus4_ifid = 32'h200; imm_ext = 32'hFFFF_FFFF; mem_rdata_exmem = 32'h1234;
    set_in(1'b1, 1'b1, 5'd5, 5'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 1'b1, 5'd5);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    set_in(1'b1, 1'b1, 5'd5, 5'd0, 32'd0, 32'd0, 2'b10, 2'b00, 1'b0, 1'b0, 5'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h1FC);
    mem_rdata_exmem = 32'd0; wb_data_memwb = 32'h1234;
    set_in(1'b1, 1'b1, 5'd5, 5'd0, 32'd0, 32'd0, 2'b11, 2'b00, 1'b0, 1'b0, 5'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h1FC);
    idle_cycle();

    // no hazard: beq 7/8 not taken, bne 7/8 taken
    pc_plus4_ifid = 32'h40; imm_ext = 32'd3;
    set_in(1'b1, 1'b0, 5'd1, 5'd2, 32'd7, 32'd8, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    set_in(1'b1, 1'b1, 5'd1, 5'd2, 32'd7, 32'd8, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h4C);

    // target wraps
    pc_plus4_ifid = 32'hFFFF_FFFC; imm_ext = 32'd2;
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h4);

    // hazard on rs and rt together: single stall
    pc_plus4_ifid = 32'h80; imm_ext = 32'd0; alu_result_exmem = 32'd42;
    set_in(1'b1, 1'b0, 5'd3, 5'd3, 32'd5, 32'd6, 2'b00, 2'b00, 1'b1, 1'b0, 5'd3);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    set_in(1'b1, 1'b0, 5'd3, 5'd3, 32'd5, 32'd6, 2'b01, 2'b01, 1'b0, 1'b0, 5'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h80);
    idle_cycle();

    // writer to $0 is not a hazard
    pc_plus4_ifid = 32'h10; imm_ext = 32'd1;
    set_in(1'b1, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 1'b0, 5'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h14);

    // reset in the stall cycle of a load hazard
    set_in(1'b1, 1'b0, 5'd5, 5'd6, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 1'b1, 5'd5);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    reset = 1'b0;
    idle_cycle();
    pc_plus4_ifid = 32'h20; imm_ext = 32'd0;
    set_in(1'b1, 1'b0, 5'd5, 5'd6, 32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h20);

    // drive counters past the 3-bit maximum
    for (int i = 0; i < 9; i++) begin
      set_in(1'b1, 1'b0, 5'd1, 5'd2, 32'd7, 32'd7, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h20);
    end
    for (int i = 0; i < 9; i++) begin
      set_in(1'b1, 1'b0, 5'd1, 5'd2, 32'd7, 32'd7, 2'b00, 2'b00, 1'b1, 1'b0, 5'd1);
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
      set_in(1'b1, 1'b0, 5'd1, 5'd2, 32'd7, 32'd7, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h20);
    end
    idle_cycle();

    repeat (3) @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      check("pending_expectations", d, q[d].size(), 32'd0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
